logarithm: RTL

- Iterative natural-logarithm unit; the inverse companion of the `exponential` block.
- Takes a fixed-point value y in [1, 4) in the same 2-bit-integer / 16-bit-fraction format that `exponential` produces, and returns ln(y) as a 16-bit fraction.
- Uses multiplicative normalisation with a small constant ROM, one iteration per clock.
- Same start/done handshake as `exponential`, so the two can be chained (exp → log) for round-trip checking.

---
 rtl/logarithm.sv | 124 ++++++++++++
 1 files changed

// File: rtl/logarithm.sv
// Iterative natural logarithm by multiplicative normalisation.
// Input y is 2.16 fixed point in [1, 4); the output is ln(y) as a 16-bit fraction.
// Each CALC cycle tries to grow z by a factor (1 + 2^-k) without passing y.
// When a step is accepted, ln(1 + 2^-k) is added to the accumulator.
module logarithm #(
  parameter int N_ITER = 16,
  parameter int FW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    intpart,
  input  logic [FW-1:0] fracpart,
  output logic          done,
  output logic [FW-1:0] result,
  output logic          err
);

  localparam int YW = FW + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_next;
  logic [YW-1:0] z, y_reg, t;
  logic [FW:0]   acc, acc_next;
  logic [3:0]    k;
  logic          last_iter;
  logic          take;

  // ln(1 + 2^-k) scaled by 2^16 and rounded to nearest.
  function automatic logic [FW-1:0] ln_rom(input logic [3:0] idx);
    logic [FW-1:0] v;
    case (idx)
      4'd0:    v = 16'd45426;
      4'd1:    v = 16'd26573;
      4'd2:    v = 16'd14624;
      4'd3:    v = 16'd7719;
      4'd4:    v = 16'd3973;
      4'd5:    v = 16'd2017;
      4'd6:    v = 16'd1016;
      4'd7:    v = 16'd510;
      4'd8:    v = 16'd256;
      4'd9:    v = 16'd128;
      4'd10:   v = 16'd64;
      4'd11:   v = 16'd32;
      4'd12:   v = 16'd16;
      4'd13:   v = 16'd8;
      4'd14:   v = 16'd4;
      default: v = 16'd2;
    endcase
    return v;
  endfunction

  // Candidate step and accumulator update for the current iteration.
  always_comb begin
    t         = z + (z >> k);
    take      = (t <= y_reg);
    acc_next  = take ? acc + {1'b0, ln_rom(k)} : acc;
    last_iter = (k == 4'(N_ITER - 1));
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: operand capture, iteration, and result/error registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z      <= '0;
      y_reg  <= '0;
      acc    <= '0;
      k      <= '0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      done <= (state == CALC) && last_iter;
      case (state)
        IDLE: begin
          if (start) begin
            y_reg <= {intpart, fracpart};
            z     <= {2'b01, {FW{1'b0}}};
            acc   <= '0;
            k     <= '0;
            err   <= 1'b0;
          end
        end
        CALC: begin
          if (take) z <= t;
          acc <= acc_next;
          k   <= k + 4'd1;
          if (last_iter) begin
            // y < 1 has a negative log; y >= 3 or accumulator overflow saturates.
            if (y_reg[YW-1:FW] == 2'd0) begin
              result <= '0;
              err    <= 1'b1;
            end else if (y_reg[YW-1:FW] == 2'd3 || acc_next[FW]) begin
              result <= '1;
              err    <= 1'b1;
            end else begin
              result <= acc_next[FW-1:0];
              err    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
